pipeline_reg_if_id: RTL and testbench



---
 rtl/pipeline_reg_if_id.sv | 46 ++++
 tb/tb_pipeline_reg_if_id.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/pipeline_reg_if_id.sv
// IF/ID pipeline register: one-cycle latency; rst > flush > stall > load priority.
// No handshake: stall holds contents and upstream must keep its outputs stable.
module pipeline_reg_if_id #(
  parameter int              XLEN = 32,
  parameter logic [XLEN-1:0] NOP  = XLEN'(32'h0000_0013)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            flush,
  input  logic [XLEN-1:0] inst_in,
  input  logic [XLEN-1:0] pc_in,
  input  logic            valid_in,
  output logic [XLEN-1:0] inst_out,
  output logic [XLEN-1:0] pc_out,
  output logic [XLEN-1:0] pc_plus4_out,
  output logic            valid_out
);

  logic [XLEN-1:0] inst_q;
  logic [XLEN-1:0] pc_q;
  logic            valid_q;

  // Flush keeps pc_in so the bubble still carries the redirect target's PC.
  always_ff @(posedge clk) begin
    if (rst) begin
      inst_q  <= NOP;
      pc_q    <= '0;
      valid_q <= 1'b0;
    end else if (flush) begin
      inst_q  <= NOP;
      pc_q    <= pc_in;
      valid_q <= 1'b0;
    end else if (!stall) begin
      inst_q  <= inst_in;
      pc_q    <= pc_in;
      valid_q <= valid_in;
    end
  end

  assign inst_out     = inst_q;
  assign pc_out       = pc_q;
  assign pc_plus4_out = pc_q + XLEN'(4);
  assign valid_out    = valid_q;

endmodule

// File: tb/tb_pipeline_reg_if_id.sv
// Bench for pipeline_reg_if_id: table of vectors plus a streaming sequence,
// expectations queued at drive time and checked after each rising edge.
module tb_pipeline_reg_if_id;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst, stall, flush, valid_in;
  logic [XLEN-1:0] inst_in, pc_in;
  logic [XLEN-1:0] inst_out, pc_out, pc_plus4_out;
  logic            valid_out;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    string           name;
    logic            rst, stall, flush;
    logic [XLEN-1:0] inst, pc;
    logic            valid;
    logic [XLEN-1:0] e_inst, e_pc, e_p4;
    logic            e_valid;
  } vec_t;

  typedef struct {
    string           name;
    logic [XLEN-1:0] inst, pc, p4;
    logic            valid;
  } exp_t;

  exp_t sb[$];

  pipeline_reg_if_id #(.XLEN(XLEN)) dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .flush        (flush),
    .inst_in      (inst_in),
    .pc_in        (pc_in),
    .valid_in     (valid_in),
    .inst_out     (inst_out),
    .pc_out       (pc_out),
    .pc_plus4_out (pc_plus4_out),
    .valid_out    (valid_out)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string name, input logic [XLEN-1:0] got, input logic [XLEN-1:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic check_out();
    exp_t e;
    if (sb.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL scoreboard: got empty queue want pending entry");
      return;
    end
    e = sb.pop_front();
    cmp({e.name, ".inst"},  inst_out,                e.inst);
    cmp({e.name, ".pc"},    pc_out,                  e.pc);
    cmp({e.name, ".pc4"},   pc_plus4_out,            e.p4);
    cmp({e.name, ".valid"}, XLEN'(valid_out),        XLEN'(e.valid));
  endtask

  task automatic apply(input vec_t v);
    exp_t e;
    @(negedge clk);
    rst      = v.rst;
    stall    = v.stall;
    flush    = v.flush;
    inst_in  = v.inst;
    pc_in    = v.pc;
    valid_in = v.valid;
    e.name  = v.name;
    e.inst  = v.e_inst;
    e.pc    = v.e_pc;
    e.p4    = v.e_p4;
    e.valid = v.e_valid;
    sb.push_back(e);
    @(posedge clk);
    #1;
    check_out();
  endtask

  function automatic vec_t mk(input string name, input logic r, input logic s, input logic f,
                              input logic [XLEN-1:0] inst, input logic [XLEN-1:0] pc,
                              input logic vld, input logic [XLEN-1:0] ei,
                              input logic [XLEN-1:0] ep, input logic [XLEN-1:0] e4,
                              input logic ev);
    vec_t v;
    v.name = name; v.rst = r; v.stall = s; v.flush = f;
    v.inst = inst; v.pc = pc; v.valid = vld;
    v.e_inst = ei; v.e_pc = ep; v.e_p4 = e4; v.e_valid = ev;
    return v;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    n_err++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1);
  end

  initial begin
    vec_t tbl[$];
    logic [XLEN-1:0] r;

    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    inst_in = '0; pc_in = '0; valid_in = 1'b0;

    //          name          rst  stl  fls  inst           pc             v     e_inst         e_pc           e_p4           e_v
    tbl.push_back(mk("rst0",     1, 0, 0, 32'hDEADBEEF, 32'h0000_0050, 1, 32'h0000_0013, 32'h0,         32'h4,         0));
    tbl.push_back(mk("rst1",     1, 0, 0, 32'hDEADBEEF, 32'h0000_0050, 1, 32'h0000_0013, 32'h0,         32'h4,         0));
    tbl.push_back(mk("load",     0, 0, 0, 32'h12345678, 32'h0000_0200, 1, 32'h12345678, 32'h0000_0200, 32'h0000_0204, 1));
    tbl.push_back(mk("stall0",   0, 1, 0, 32'hAAAAAAAA, 32'h0000_0204, 1, 32'h12345678, 32'h0000_0200, 32'h0000_0204, 1));
    tbl.push_back(mk("stall1",   0, 1, 0, 32'hAAAAAAAA, 32'h0000_0204, 1, 32'h12345678, 32'h0000_0200, 32'h0000_0204, 1));
    tbl.push_back(mk("stall2",   0, 1, 0, 32'hAAAAAAAA, 32'h0000_0204, 1, 32'h12345678, 32'h0000_0200, 32'h0000_0204, 1));
    tbl.push_back(mk("unstall",  0, 0, 0, 32'hAAAAAAAA, 32'h0000_0204, 1, 32'hAAAAAAAA, 32'h0000_0204, 32'h0000_0208, 1));
    tbl.push_back(mk("flushstl", 0, 1, 1, 32'h00500093, 32'h0000_0300, 1, 32'h0000_0013, 32'h0000_0300, 32'h0000_0304, 0));
    tbl.push_back(mk("wrap",     0, 0, 0, 32'h00000000, 32'hFFFF_FFFC, 0, 32'h00000000, 32'hFFFF_FFFC, 32'h0000_0000, 0));
    tbl.push_back(mk("cafe",     0, 0, 0, 32'hCAFEBABE, 32'h0000_0400, 1, 32'hCAFEBABE, 32'h0000_0400, 32'h0000_0404, 1));
    tbl.push_back(mk("cafehold", 0, 1, 0, 32'h11111111, 32'h0000_0404, 1, 32'hCAFEBABE, 32'h0000_0400, 32'h0000_0404, 1));
    tbl.push_back(mk("rststall", 1, 1, 0, 32'h11111111, 32'h0000_0404, 1, 32'h0000_0013, 32'h0,         32'h4,         0));
    tbl.push_back(mk("postrst",  0, 1, 0, 32'h22222222, 32'h0000_0500, 1, 32'h0000_0013, 32'h0,         32'h4,         0));
    tbl.push_back(mk("flush",    0, 0, 1, 32'h33333333, 32'h0000_0600, 1, 32'h0000_0013, 32'h0000_0600, 32'h0000_0604, 0));
    tbl.push_back(mk("rstflush", 1, 0, 1, 32'h44444444, 32'h0000_0700, 1, 32'h0000_0013, 32'h0,         32'h4,         0));

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

    // Streaming: each edge must present the word driven just before it.
    for (int i = 0; i < 10; i++) begin
      r = $urandom();
      apply(mk($sformatf("strm%0d", i), 0, 0, 0, r, 32'h100 + 32'(4 * i), 1,
               r, 32'h100 + 32'(4 * i), 32'h104 + 32'(4 * i), 1));
    end

    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL sb_drain: got %0d left want 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
